// File: rtl/iob_ram_at2p_fifo_ctrl.sv
// FIFO controller for an external two-port RAM with a registered read port.
// One word is prefetched into the RAM output register so that pops can run
// at one word per cycle. Total capacity is DEPTH + 1 words.
module iob_ram_at2p_fifo_ctrl #(
  parameter int unsigned DATA_W = 21,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              w_valid_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              w_ready_o,
  output logic              r_valid_o,
  output logic [DATA_W-1:0] r_data_o,
  input  logic              r_ready_i,
  output logic [ADDR_W:0]   level_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              ext_mem_w_clk_o,
  output logic              ext_mem_w_en_o,
  output logic [ADDR_W-1:0] ext_mem_w_addr_o,
  output logic [DATA_W-1:0] ext_mem_w_data_o,
  output logic              ext_mem_r_clk_o,
  output logic              ext_mem_r_en_o,
  output logic [ADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [DATA_W-1:0] ext_mem_r_data_i
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   mem_cnt_q, mem_cnt_d;
  logic              out_vld_q, out_vld_d;

  logic push;
  logic pop;
  logic rd;
  logic full;

  assign full      = (mem_cnt_q == DEPTH);
  assign full_o    = full;
  assign w_ready_o = rst_n_i & ~full;
  assign push      = w_valid_i & w_ready_o;
  assign pop       = out_vld_q & r_ready_i;
  // Registered count excludes this cycle's write, so a read never targets
  // the address being written in the same cycle.
  assign rd        = rst_n_i & (mem_cnt_q != '0) & (~out_vld_q | pop);

  assign level_o   = mem_cnt_q + {{ADDR_W{1'b0}}, out_vld_q};
  assign empty_o   = (level_o == '0);

  assign r_valid_o = out_vld_q;
  assign r_data_o  = ext_mem_r_data_i;

  assign ext_mem_w_clk_o  = clk_i;
  assign ext_mem_w_en_o   = push;
  assign ext_mem_w_addr_o = wptr_q;
  assign ext_mem_w_data_o = w_data_i;
  assign ext_mem_r_clk_o  = clk_i;
  assign ext_mem_r_en_o   = rd;
  assign ext_mem_r_addr_o = rptr_q;

  // Next-state for pointers, RAM occupancy and output-register valid.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    mem_cnt_d = mem_cnt_q;
    out_vld_d = out_vld_q;

    if (push) wptr_d = wptr_q + ADDR_W'(1);
    if (rd)   rptr_d = rptr_q + ADDR_W'(1);

    case ({push, rd})
      2'b10:   mem_cnt_d = mem_cnt_q + (ADDR_W+1)'(1);
      2'b01:   mem_cnt_d = mem_cnt_q - (ADDR_W+1)'(1);
      default: mem_cnt_d = mem_cnt_q;
    endcase

    if (rd)       out_vld_d = 1'b1;
    else if (pop) out_vld_d = 1'b0;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      mem_cnt_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      mem_cnt_q <= mem_cnt_d;
      out_vld_q <= out_vld_d;
    end
  end

endmodule

// File: tb/tb_iob_ram_at2p_fifo_ctrl.sv
// Bench for iob_ram_at2p_fifo_ctrl with DATA_W=8, ADDR_W=2 and a behavioural
// two-port RAM with registered, hold-on-idle read data.
module tb_iob_ram_at2p_fifo_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic          w_ready;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          r_ready;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          m_w_clk, m_w_en, m_r_clk, m_r_en;
  logic [AW-1:0] m_w_addr, m_r_addr;
  logic [DW-1:0] m_w_data, m_r_data;

  logic [DW-1:0] ram [4];

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;
  int unsigned pop_cnt = 0;
  logic [DW-1:0] sb_q [$];

  always #5 clk = ~clk;

  iob_ram_at2p_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .w_valid_i       (w_valid),
    .w_data_i        (w_data),
    .w_ready_o       (w_ready),
    .r_valid_o       (r_valid),
    .r_data_o        (r_data),
    .r_ready_i       (r_ready),
    .level_o         (level),
    .full_o          (full),
    .empty_o         (empty),
    .ext_mem_w_clk_o (m_w_clk),
    .ext_mem_w_en_o  (m_w_en),
    .ext_mem_w_addr_o(m_w_addr),
    .ext_mem_w_data_o(m_w_data),
    .ext_mem_r_clk_o (m_r_clk),
    .ext_mem_r_en_o  (m_r_en),
    .ext_mem_r_addr_o(m_r_addr),
    .ext_mem_r_data_i(m_r_data)
  );

  // External RAM: write port and registered read port.
  always @(posedge m_w_clk) if (m_w_en) ram[m_w_addr] <= m_w_data;
  always @(posedge m_r_clk) if (m_r_en) m_r_data <= ram[m_r_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs are stable across the negedge, so handshakes seen
  // here are exactly those taken at the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (r_valid && r_ready) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          check("pop_data", 32'(r_data), 32'(sb_q.pop_front()));
          pop_cnt++;
        end
      end
      if (w_valid && w_ready) sb_q.push_back(w_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    w_valid = 1'b1;
    w_data  = 8'h55;
    r_ready = 1'b0;

    // Reset held three cycles with a push request present.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_w_en", 32'(m_w_en), 32'd0);
      check("rst_w_ready", 32'(w_ready), 32'd0);
      check("rst_r_en", 32'(m_r_en), 32'd0);
    end
    rst_n   = 1'b1;
    w_valid = 1'b0;
    #1;
    check("rel_r_valid", 32'(r_valid), 32'd0);
    check("rel_empty", 32'(empty), 32'd1);
    check("rel_level", 32'(level), 32'd0);
    check("rel_w_ready", 32'(w_ready), 32'd1);
    check("rel_full", 32'(full), 32'd0);

    // Latency: push in N, read issue in N+1, valid in N+2, then hold.
    w_valid = 1'b1;
    w_data  = 8'hA5;
    #1;
    check("lat_w_en", 32'(m_w_en), 32'd1);
    check("lat_w_addr", 32'(m_w_addr), 32'd0);
    tick();
    w_valid = 1'b0;
    #1;
    check("lat_r_en", 32'(m_r_en), 32'd1);
    check("lat_r_addr", 32'(m_r_addr), 32'd0);
    check("lat_r_valid_n1", 32'(r_valid), 32'd0);
    tick();
    check("lat_r_valid_n2", 32'(r_valid), 32'd1);
    check("lat_r_data_n2", 32'(r_data), 32'hA5);
    check("lat_level", 32'(level), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_r_valid", 32'(r_valid), 32'd1);
      check("hold_r_data", 32'(r_data), 32'hA5);
    end
    r_ready = 1'b1;
    #1;
    check("lat_level_before_pop", 32'(level), 32'd1);
    tick();
    r_ready = 1'b0;
    check("lat_r_valid_after_pop", 32'(r_valid), 32'd0);
    check("lat_level_after_pop", 32'(level), 32'd0);
    check("lat_empty_after_pop", 32'(empty), 32'd1);

    // Fill to capacity: five accepted, sixth rejected.
    for (int i = 1; i <= 6; i++) begin
      w_valid = 1'b1;
      w_data  = 8'(i);
      #1;
      if (i == 6) check("fill_reject_ready", 32'(w_ready), 32'd0);
      tick();
    end
    #1;
    check("fill_level", 32'(level), 32'd5);
    check("fill_full", 32'(full), 32'd1);
    check("fill_w_ready", 32'(w_ready), 32'd0);
    check("fill_r_valid", 32'(r_valid), 32'd1);
    check("fill_r_data", 32'(r_data), 32'h01);
    check("fill_sb_size", 32'(sb_q.size()), 32'd5);
    w_valid = 1'b0;

    // Drain after full: five consecutive pops.
    r_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("drain_r_valid", 32'(r_valid), 32'd1);
      if (k == 0) check("drain_w_ready_first", 32'(w_ready), 32'd0);
      if (k == 1) check("drain_w_ready_freed", 32'(w_ready), 32'd1);
      if (k == 1) check("drain_level", 32'(level), 32'd4);
      tick();
    end
    #1;
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_r_valid_end", 32'(r_valid), 32'd0);
    check("drain_sb_size", 32'(sb_q.size()), 32'd0);

    // Streaming with pointer wrap.
    pop_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      w_valid = 1'b1;
      w_data  = 8'(i);
      #1;
      check("stream_level_le2", 32'(level <= 3'd2), 32'd1);
      check("stream_full", 32'(full), 32'd0);
      check("stream_w_ready", 32'(w_ready), 32'd1);
      tick();
    end
    w_valid = 1'b0;
    for (int k = 0; k < 8 && !empty; k++) tick();
    #1;
    check("stream_empty", 32'(empty), 32'd1);
    check("stream_pop_cnt", pop_cnt, 32'd20);

    // Mid-operation reset discards contents.
    r_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_valid = 1'b1;
      w_data  = 8'h11 * 8'(i + 1);
      tick();
    end
    w_valid = 1'b0;
    #1;
    check("mid_level", 32'(level), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rst_r_valid", 32'(r_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    w_valid = 1'b1;
    w_data  = 8'h77;
    tick();
    w_valid = 1'b0;
    r_ready = 1'b1;
    #1;
    check("mid_r_valid_n1", 32'(r_valid), 32'd0);
    tick();
    check("mid_r_valid_n2", 32'(r_valid), 32'd1);
    check("mid_r_data", 32'(r_data), 32'h77);
    tick();
    check("mid_empty_end", 32'(empty), 32'd1);
    check("mid_sb_size", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
